// File: rtl/cholesky_inv_pkg.sv
// rtl/cholesky_inv_pkg.sv - shared constants for the Cholesky inverse sequencer
package cholesky_inv_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECOMP = 3'd1;
  localparam logic [2:0] S_INV    = 3'd2;
  localparam logic [2:0] S_TRAN   = 3'd3;
  localparam logic [2:0] S_MULT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [1:0] STG_CHOL = 2'd0;
  localparam logic [1:0] STG_INV  = 2'd1;
  localparam logic [1:0] STG_TRAN = 2'd2;
  localparam logic [1:0] STG_MULT = 2'd3;

  localparam int TRAN_LAT = 2;
  localparam int N        = 8;

  function automatic logic [1:0] stage_of(input logic [2:0] s);
    case (s)
      S_INV:   stage_of = STG_INV;
      S_TRAN:  stage_of = STG_TRAN;
      S_MULT:  stage_of = STG_MULT;
      default: stage_of = STG_CHOL;
    endcase
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// rtl/stage_watchdog.sv - cycles-since-start counter with timeout flag
module stage_watchdog #(
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            active,
  output logic [TO_W-1:0] delay,
  output logic            timeout
);

  logic [TO_W-1:0] cnt;

  // The start-pulse cycle reads as delay 0; the register already holds 1 for the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= TO_W'(1);
    end else if (active && (cnt != '1)) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign delay   = clr ? '0 : cnt;
  assign timeout = active && !clr && (cnt == TO_W'(TIMEOUT));

endmodule

// File: rtl/cholesky_inv_seq.sv
// rtl/cholesky_inv_seq.sv - four-stage job sequencer for the 8x8 Hermitian inverse pipeline
module cholesky_inv_seq
  import cholesky_inv_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 16,
  parameter int CYC_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_stage,
  output logic             chol_start,
  input  logic             chol_done,
  output logic             inv_start,
  input  logic             inv_done,
  output logic             tran_start,
  input  logic             tran_done,
  output logic             mult_start,
  input  logic             mult_done,
  output logic [7:0]       job_cnt,
  output logic [CYC_W-1:0] last_cycles
);

  logic [2:0]       state, next_state;
  logic [TO_W-1:0]  delay;
  logic             timeout;
  logic             any_pulse;
  logic             sampled;
  logic             err_set;
  logic             job_start;
  logic [CYC_W-1:0] job_cyc;

  assign any_pulse = chol_start | inv_start | tran_start | mult_start;
  assign busy      = (state == S_DECOMP) || (state == S_INV) || (state == S_TRAN) || (state == S_MULT);
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERR);
  assign sampled   = (delay != '0);
  assign job_start = (next_state == S_DECOMP) && (state != S_DECOMP);

  stage_watchdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (any_pulse),
    .active  (busy),
    .delay   (delay),
    .timeout (timeout)
  );

  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    if (abort) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) next_state = S_DECOMP;
        S_DONE: next_state = start ? S_DECOMP : S_IDLE;
        S_DECOMP: begin
          if (sampled && chol_done) next_state = S_INV;
          else if (timeout) err_set = 1'b1;
        end
        S_INV: begin
          if (sampled && inv_done) next_state = S_MULT - 3'd1;
          else if (timeout) err_set = 1'b1;
        end
        // Transpose has a fixed latency: early or missing done is a fault.
        S_TRAN: begin
          if ((delay == TO_W'(1)) && tran_done) err_set = 1'b1;
          else if (delay == TO_W'(TRAN_LAT)) begin
            if (tran_done) next_state = S_MULT;
            else err_set = 1'b1;
          end else if (timeout) err_set = 1'b1;
        end
        S_MULT: begin
          if (sampled && mult_done) next_state = S_DONE;
          else if (timeout) err_set = 1'b1;
        end
        S_ERR:   next_state = S_ERR;
        default: next_state = S_IDLE;
      endcase
      if (err_set) next_state = S_ERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      chol_start <= 1'b0;
      inv_start  <= 1'b0;
      tran_start <= 1'b0;
      mult_start <= 1'b0;
      err_stage  <= STG_CHOL;
    end else begin
      state      <= next_state;
      chol_start <= job_start;
      inv_start  <= (next_state == S_INV)  && (state != S_INV);
      tran_start <= (next_state == S_TRAN) && (state != S_TRAN);
      mult_start <= (next_state == S_MULT) && (state != S_MULT);
      if (job_start) err_stage <= STG_CHOL;
      else if (err_set) err_stage <= stage_of(state);
    end
  end

  // job_cyc reads 1 in the chol_start cycle, so in DONE it holds the inclusive job length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_cyc     <= '0;
      job_cnt     <= '0;
      last_cycles <= '0;
    end else begin
      if (job_start) job_cyc <= CYC_W'(1);
      else if (busy && (job_cyc != '1)) job_cyc <= job_cyc + CYC_W'(1);
      if (state == S_DONE) begin
        job_cnt     <= job_cnt + 8'd1;
        last_cycles <= job_cyc;
      end
    end
  end

endmodule
